// File: rtl/multicycle_ctrl_unit_if.sv
// Data-bus handshake bundle between the multicycle control unit and memory.
// master: the control unit (drives write/read strobes and the abort pulse).
// slave : the memory side (drives the completion strobe).
interface multicycle_ctrl_unit_if;
  logic busWe;
  logic busRe;
  logic busReady;
  logic busErr;

  modport master (output busWe, output busRe, output busErr, input busReady);
  modport slave  (input busWe, input busRe, input busErr, output busReady);
endinterface

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RV32 control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback phases, with a bounded wait on the data bus.
// Optional feature: define ILLEGAL_TRAP_EN to send unknown opcodes to a
// sticky TRAP state; without it they fall back to FETCH and illegal is 0.
module multicycle_ctrl_unit #(
  parameter int BUS_TIMEOUT = 15,
  parameter int RFWD_SEL_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instrCode,
  multicycle_ctrl_unit_if.master bus,
  output logic                  PCEn,
  output logic                  regFileWe,
  output logic                  aluSrcMuxSel,
  output logic                  branch,
  output logic                  jal,
  output logic                  jalr,
  output logic [3:0]            aluControl,
  output logic [RFWD_SEL_W-1:0] RFWDSrcMuxSel,
  output logic                  illegal
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] R_EXE  = 4'd2;
  localparam logic [3:0] I_EXE  = 4'd3;
  localparam logic [3:0] B_EXE  = 4'd4;
  localparam logic [3:0] LU_EXE = 4'd5;
  localparam logic [3:0] AU_EXE = 4'd6;
  localparam logic [3:0] J_EXE  = 4'd7;
  localparam logic [3:0] JL_EXE = 4'd8;
  localparam logic [3:0] S_EXE  = 4'd9;
  localparam logic [3:0] S_MEM  = 4'd10;
  localparam logic [3:0] L_EXE  = 4'd11;
  localparam logic [3:0] L_MEM  = 4'd12;
  localparam logic [3:0] L_WB   = 4'd13;
  localparam logic [3:0] TRAP   = 4'd14;

`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] UNKNOWN_OP_NEXT = TRAP;
`else
  localparam logic [3:0] UNKNOWN_OP_NEXT = FETCH;
`endif

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [RFWD_SEL_W-1:0] RFWD_ALU   = '0;
  localparam logic [RFWD_SEL_W-1:0] RFWD_BUS   = RFWD_SEL_W'(1);
  localparam logic [RFWD_SEL_W-1:0] RFWD_IMM   = RFWD_SEL_W'(2);
  localparam logic [RFWD_SEL_W-1:0] RFWD_AUIPC = RFWD_SEL_W'(3);
  localparam logic [RFWD_SEL_W-1:0] RFWD_PC4   = RFWD_SEL_W'(4);

  // A zero timeout still needs a one-bit counter so the declaration is legal.
  localparam int              CNT_W       = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(BUS_TIMEOUT);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busErr_q, busErr_d;
  logic             timeout_hit;
  logic             bus_we, bus_re;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       unused_instr;

  assign opcode       = instrCode[6:0];
  assign funct3       = instrCode[14:12];
  assign bit30        = instrCode[30];
  assign unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign timeout_hit = (BUS_TIMEOUT > 0) && (cnt_q == TIMEOUT_VAL);

  // Next-state, wait-counter and abort-pulse logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    busErr_d = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          7'b0110011: state_d = R_EXE;
          7'b0010011: state_d = I_EXE;
          7'b1100011: state_d = B_EXE;
          7'b0110111: state_d = LU_EXE;
          7'b0010111: state_d = AU_EXE;
          7'b1101111: state_d = J_EXE;
          7'b1100111: state_d = JL_EXE;
          7'b0100011: state_d = S_EXE;
          7'b0000011: state_d = L_EXE;
          default:    state_d = UNKNOWN_OP_NEXT;
        endcase
      end
      R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE: state_d = FETCH;
      S_EXE: begin
        state_d = S_MEM;
        cnt_d   = '0;
      end
      L_EXE: begin
        state_d = L_MEM;
        cnt_d   = '0;
      end
      S_MEM, L_MEM: begin
        // A completion strobe in the same cycle as the timeout wins.
        if (bus.busReady) begin
          state_d = (state_q == S_MEM) ? FETCH : L_WB;
        end else if (timeout_hit) begin
          state_d  = FETCH;
          busErr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      L_WB:    state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // State, wait counter and abort pulse; reset aborts any bus transaction at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busErr_q <= busErr_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag raised on entry into TRAP; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_d == TRAP) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Moore output decode from the registered state only.
  always_comb begin
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    bus_we        = 1'b0;
    bus_re        = 1'b0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    aluControl    = ALU_ADD;
    RFWDSrcMuxSel = RFWD_ALU;
    case (state_q)
      FETCH: PCEn = 1'b1;
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = {bit30, funct3};
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // Only the shift-right immediates use bit30 (SRLI/SRAI); elsewhere it is immediate data.
        aluControl   = (funct3 == 3'b101) ? {bit30, funct3} : {1'b0, funct3};
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = {bit30, funct3};
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_IMM;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_AUIPC;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
        jalr          = 1'b1;
      end
      S_EXE: aluSrcMuxSel = 1'b1;
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        bus_we       = 1'b1;
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_BUS;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_BUS;
        bus_re        = 1'b1;
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_BUS;
      end
      default: ;
    endcase
  end

  assign bus.busWe  = bus_we;
  assign bus.busRe  = bus_re;
  assign bus.busErr = busErr_q;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Scoreboard bench for multicycle_ctrl_unit: each scenario queues the
// expected per-cycle control vector (plus the busReady to drive that cycle),
// then pops and compares one entry per clock on the falling edge.
module tb_multicycle_ctrl_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, illegal;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;

  multicycle_ctrl_unit_if bus ();

  multicycle_ctrl_unit #(.BUS_TIMEOUT(15), .RFWD_SEL_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .instrCode    (instrCode),
    .bus          (bus.master),
    .PCEn         (PCEn),
    .regFileWe    (regFileWe),
    .aluSrcMuxSel (aluSrcMuxSel),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .aluControl   (aluControl),
    .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control-byte bit positions: {PCEn, regFileWe, aluSrc, busWe, busRe, branch, jal, jalr}
  localparam logic [7:0] C_PC   = 8'h80;
  localparam logic [7:0] C_WE   = 8'h40;
  localparam logic [7:0] C_SRC  = 8'h20;
  localparam logic [7:0] C_BWE  = 8'h10;
  localparam logic [7:0] C_BRE  = 8'h08;
  localparam logic [7:0] C_BR   = 8'h04;
  localparam logic [7:0] C_JAL  = 8'h02;
  localparam logic [7:0] C_JALR = 8'h01;

  typedef struct {
    logic        rdy;
    logic [16:0] exp;
  } entry_t;

  entry_t sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic logic [16:0] mk(input logic [7:0] ctl, input logic [3:0] alu,
                                     input logic [2:0] rfwd, input logic berr, input logic ill);
    return {ctl, alu, rfwd, berr, ill};
  endfunction

  function automatic logic [31:0] mk_instr(input logic b30, input logic [2:0] f3, input logic [6:0] op);
    return {1'b0, b30, 15'h0, f3, 5'h0, op};
  endfunction

  function automatic logic [16:0] observe();
    return {PCEn, regFileWe, aluSrcMuxSel, bus.busWe, bus.busRe, branch, jal, jalr,
            aluControl, RFWDSrcMuxSel, bus.busErr, illegal};
  endfunction

  task automatic push(input logic rdy, input logic [16:0] exp);
    entry_t e;
    e.rdy = rdy;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Advance one cycle: pop the next expectation, sample at the falling edge, drive busReady.
  task automatic next_cycle(output logic [16:0] obs, output logic [16:0] exp);
    entry_t e;
    e = sb_q.pop_front();
    @(negedge clk);
    obs = observe();
    exp = e.exp;
    bus.busReady = e.rdy;
  endtask

  logic [16:0] F_V, FB_V, D_V;

  task automatic test_reset();
    logic [16:0] obs;
    #3;
    obs = observe();
    n_checks++;
    if (obs !== F_V) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs, F_V);
    end
    @(negedge clk);
    obs = observe();
    n_checks++;
    if (obs !== F_V) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", obs, F_V);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [16:0] obs, exp;
    int cyc = 0;
    instrCode = mk_instr(1'b0, 3'b000, 7'b0110011);  // ADD; busReady outside memory states is ignored
    push(1'b1, F_V); push(1'b1, D_V); push(1'b1, mk(C_WE, 4'b0000, 3'd0, 1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL rtype_add cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
    instrCode = mk_instr(1'b1, 3'b000, 7'b0110011);  // SUB
    push(1'b0, F_V); push(1'b0, D_V); push(1'b0, mk(C_WE, 4'b1000, 3'd0, 1'b0, 1'b0));
    cyc = 0;
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL rtype_sub cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
    instrCode = mk_instr(1'b0, 3'b001, 7'b1100011);  // BNE
    push(1'b0, F_V); push(1'b0, D_V); push(1'b0, mk(C_BR, 4'b0001, 3'd0, 1'b0, 1'b0));
    cyc = 0;
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL branch_bne cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
  endtask

  task automatic test_itype();
    logic [16:0] obs, exp;
    logic [31:0] instr_tab [3];
    logic [3:0]  alu_tab   [3];
    instr_tab[0] = mk_instr(1'b1, 3'b101, 7'b0010011); alu_tab[0] = 4'b1101;  // SRAI
    instr_tab[1] = mk_instr(1'b1, 3'b000, 7'b0010011); alu_tab[1] = 4'b0000;  // ADDI, imm bit30 set
    instr_tab[2] = mk_instr(1'b1, 3'b011, 7'b0010011); alu_tab[2] = 4'b0011;  // SLTIU, imm bit30 set
    for (int k = 0; k < 3; k++) begin
      instrCode = instr_tab[k];
      push(1'b0, F_V); push(1'b0, D_V); push(1'b0, mk(C_WE | C_SRC, alu_tab[k], 3'd0, 1'b0, 1'b0));
      for (int c = 0; c < 3; c++) begin
        next_cycle(obs, exp);
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL itype_%0d cycle %0d: got %b expected %b", k, c, obs, exp); end
      end
    end
  endtask

  task automatic test_upper_jump();
    logic [16:0] obs, exp;
    logic [31:0] instr_tab [4];
    logic [16:0] exe_tab   [4];
    instr_tab[0] = mk_instr(1'b1, 3'b111, 7'b0110111); exe_tab[0] = mk(C_WE, 4'b0000, 3'd2, 1'b0, 1'b0);
    instr_tab[1] = mk_instr(1'b0, 3'b101, 7'b0010111); exe_tab[1] = mk(C_WE, 4'b0000, 3'd3, 1'b0, 1'b0);
    instr_tab[2] = mk_instr(1'b1, 3'b010, 7'b1101111); exe_tab[2] = mk(C_WE | C_JAL, 4'b0000, 3'd4, 1'b0, 1'b0);
    instr_tab[3] = mk_instr(1'b0, 3'b000, 7'b1100111); exe_tab[3] = mk(C_WE | C_JAL | C_JALR, 4'b0000, 3'd4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      instrCode = instr_tab[k];
      push(1'b0, F_V); push(1'b0, D_V); push(1'b0, exe_tab[k]);
      for (int c = 0; c < 3; c++) begin
        next_cycle(obs, exp);
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL upper_jump_%0d cycle %0d: got %b expected %b", k, c, obs, exp); end
      end
    end
  endtask

  task automatic test_load();
    logic [16:0] obs, exp;
    int cyc = 0;
    instrCode = mk_instr(1'b0, 3'b010, 7'b0000011);  // LW
    push(1'b0, F_V);
    push(1'b0, D_V);
    push(1'b0, mk(C_SRC, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b0, mk(C_SRC | C_BRE, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b0, mk(C_SRC | C_BRE, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b0, mk(C_SRC | C_BRE, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b1, mk(C_SRC | C_BRE, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b0, mk(C_WE | C_SRC, 4'b0000, 3'd1, 1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL load_wait3 cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
  endtask

  task automatic test_store_timeout();
    logic [16:0] obs, exp;
    int cyc = 0;
    instrCode = mk_instr(1'b0, 3'b010, 7'b0100011);  // SW
    // First pass: busReady never rises -> 16 S_MEM cycles then abort.
    push(1'b0, F_V);
    push(1'b0, D_V);
    push(1'b0, mk(C_SRC, 4'b0000, 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) push(1'b0, mk(C_SRC | C_BWE, 4'b0000, 3'd0, 1'b0, 1'b0));
    // Abort lands in FETCH with a one-cycle busErr, then the same store retries.
    push(1'b0, FB_V);
    push(1'b0, D_V);
    push(1'b0, mk(C_SRC, 4'b0000, 3'd0, 1'b0, 1'b0));
    // Second pass: busReady rises exactly when the count reaches the limit.
    for (int i = 0; i < 15; i++) push(1'b0, mk(C_SRC | C_BWE, 4'b0000, 3'd0, 1'b0, 1'b0));
    push(1'b1, mk(C_SRC | C_BWE, 4'b0000, 3'd0, 1'b0, 1'b0));
    push(1'b0, F_V);  // normal exit: no busErr
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL store_timeout cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_load();
    logic [16:0] obs, exp;
    int cyc = 0;
    // Continue from FETCH of the prior store: decode a load and stall in L_MEM.
    instrCode = mk_instr(1'b0, 3'b010, 7'b0000011);
    push(1'b0, D_V);
    push(1'b0, mk(C_SRC, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b0, mk(C_SRC | C_BRE, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b0, mk(C_SRC | C_BRE, 4'b0000, 3'd1, 1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_mid_load_pre cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
    #1 reset = 1'b1;
    #1 obs = observe();
    n_checks++;
    if (obs !== F_V) begin n_fail++; $display("FAIL reset_mid_load_async: got %b expected %b", obs, F_V); end
    for (int c = 0; c < 3; c++) begin
      bus.busReady = 1'b1;
      @(negedge clk);
      obs = observe();
      n_checks++;
      if (obs !== F_V) begin n_fail++; $display("FAIL reset_mid_load_hold cycle %0d: got %b expected %b", c, obs, F_V); end
    end
    bus.busReady = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    // After release the load replays from FETCH with a normal immediate completion.
    push(1'b0, F_V);
    push(1'b0, D_V);
    push(1'b0, mk(C_SRC, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b1, mk(C_SRC | C_BRE, 4'b0000, 3'd1, 1'b0, 1'b0));
    push(1'b0, mk(C_WE | C_SRC, 4'b0000, 3'd1, 1'b0, 1'b0));
    cyc = 0;
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_mid_load_post cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
  endtask

  task automatic test_illegal();
    logic [16:0] obs, exp;
    int cyc = 0;
    instrCode = mk_instr(1'b0, 3'b000, 7'b1111111);
    push(1'b0, F_V);
    push(1'b0, D_V);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) push(1'b0, mk(8'h00, 4'b0000, 3'd0, 1'b0, 1'b1));
`else
    push(1'b0, F_V);
    push(1'b0, D_V);
    push(1'b0, F_V);
`endif
    while (sb_q.size() > 0) begin
      next_cycle(obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL illegal_opcode cycle %0d: got %b expected %b", cyc, obs, exp); end
      cyc++;
    end
  endtask

  initial begin
    F_V  = mk(C_PC, 4'b0000, 3'd0, 1'b0, 1'b0);
    FB_V = mk(C_PC, 4'b0000, 3'd0, 1'b1, 1'b0);
    D_V  = mk(8'h00, 4'b0000, 3'd0, 1'b0, 1'b0);
    reset        = 1'b1;
    instrCode    = 32'h0;
    bus.busReady = 1'b0;

    test_reset();
    test_rtype();
    test_itype();
    test_upper_jump();
    test_load();
    test_store_timeout();
    test_reset_mid_load();
    test_illegal();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends even if sequencing goes astray.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl_unit.md
MULTICYCLE_CTRL_UNIT -- requirements
Module: multicycle_ctrl_unit

Interface
REQ-001 Parameter BUS_TIMEOUT, default 15: maximum wait cycles in a memory state before abort; 0 means wait indefinitely.
REQ-002 Parameter RFWD_SEL_W, default 3: width of RFWDSrcMuxSel.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instrCode  input  32  current instruction; opcode=[6:0], funct3=[14:12], bit30=[30].
REQ-006 busReady  input  1  data bus completion strobe, sampled in S_MEM/L_MEM only.
REQ-007 PCEn, regFileWe, aluSrcMuxSel, busWe, busRe, branch, jal, jalr  output  1 each  datapath controls.
REQ-008 aluControl  output  4  ALU operation, ADD=4'b0000.
REQ-009 RFWDSrcMuxSel  output  RFWD_SEL_W  writeback select: 0 ALU, 1 bus read data, 2 immediate (LUI), 3 PC+imm (AUIPC), 4 PC+4.
REQ-010 busErr  output  1  one-cycle pulse on bus timeout abort.
REQ-011 illegal  output  1  sticky illegal-opcode flag (tied 0 without ILLEGAL_TRAP_EN).

Function
REQ-012 States SHALL be FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP; Moore outputs from registered state only.
REQ-013 FETCH->DECODE unconditionally; FETCH SHALL assert PCEn=1, all other controls 0.
REQ-014 DECODE SHALL dispatch on opcode: 0110011 R_EXE, 0010011 I_EXE, 1100011 B_EXE, 0110111 LU_EXE, 0010111 AU_EXE, 1101111 J_EXE, 1100111 JL_EXE, 0100011 S_EXE, 0000011 L_EXE; any other opcode per REQ-026.
REQ-015 R/I/B/LU/AU/J/JL_EXE SHALL return to FETCH after one cycle; instruction latency 3 cycles.
REQ-016 R_EXE: regFileWe=1, aluControl={bit30,funct3}; B_EXE: branch=1, aluControl={bit30,funct3}.
REQ-017 I_EXE: regFileWe=1, aluSrcMuxSel=1; aluControl={bit30,funct3} when funct3=101, else {0,funct3}.
REQ-018 LU_EXE: regFileWe=1, RFWD=2; AU_EXE: regFileWe=1, RFWD=3; J_EXE: regFileWe=1, RFWD=4, jal=1; JL_EXE: same plus jalr=1.
REQ-019 S_EXE: aluSrcMuxSel=1, busWe=0; next S_MEM. L_EXE: aluSrcMuxSel=1, RFWD=1; next L_MEM.
REQ-020 S_MEM: aluSrcMuxSel=1, busWe=1 held every cycle until exit; L_MEM: aluSrcMuxSel=1, RFWD=1, busRe=1 held until exit.
REQ-021 In S_MEM/L_MEM busReady=1 SHALL exit (S_MEM->FETCH, L_MEM->L_WB) next edge; minimum store latency 4, load 5 cycles.
REQ-022 A wait counter SHALL clear on memory-state entry and increment each cycle busReady=0; counter width clog2(BUS_TIMEOUT+1).
REQ-023 When counter equals BUS_TIMEOUT (BUS_TIMEOUT>0) with busReady=0, FSM SHALL go to FETCH, pulse busErr for that next FETCH cycle, and skip L_WB.
REQ-024 busReady=1 on the same cycle the timeout is reached SHALL win: normal exit, no busErr.
REQ-025 L_WB: regFileWe=1, aluSrcMuxSel=1, RFWD=1; next FETCH.
REQ-026 Unrecognised opcode without ILLEGAL_TRAP_EN: DECODE->FETCH, no controls asserted.
REQ-027 Default for every unlisted output in any state: 0; aluControl default ADD.

Reset
REQ-028 reset=1 SHALL immediately force state=FETCH, wait counter=0, busErr=0, illegal=0, regardless of current state including mid S_MEM/L_MEM.
REQ-029 First rising edge after reset release SHALL move FETCH->DECODE with PCEn=1 during the preceding cycle.

Configuration
REQ-030 Macro ILLEGAL_TRAP_EN defined: unrecognised opcode in DECODE SHALL go to TRAP; TRAP holds all controls 0, illegal=1, remains until reset.
REQ-031 Macro ILLEGAL_TRAP_EN undefined: TRAP unreachable, illegal tied 0, behaviour per REQ-026.

Verification
REQ-032 Reset, then R-type ADD (opcode 0110011, funct3 000, bit30 0) -> FETCH PCEn=1, DECODE, R_EXE regFileWe=1 aluControl=0000, back to FETCH.
REQ-033 I-type SRAI (funct3 101, bit30 1) -> aluControl=1101; ADDI with bit30=1 -> aluControl=0000.
REQ-034 Load, busReady low 3 cycles then high -> busRe=1 for 4 L_MEM cycles, then L_WB regFileWe=1 RFWD=1, total 8 cycles.
REQ-035 Store, BUS_TIMEOUT=15, busReady held 0 -> busWe=1 for 16 S_MEM cycles, then FETCH with busErr=1 for one cycle; busReady=1 at count 15 -> no busErr.
REQ-036 reset asserted mid L_MEM -> same cycle state=FETCH, busRe=0, regFileWe never asserted.
REQ-037 Opcode 1111111 -> with ILLEGAL_TRAP_EN illegal=1 sticky, PCEn stays 0; without it returns to FETCH after DECODE.
